// File: rtl/instr_sequencer_pkg.sv
// Shared types for the instruction sequencer: FSM states and ISA fields
// used to assemble test programs.
package instr_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_END   = 3'd4
    } seq_state_e;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;

    localparam int OP_HI   = 15;
    localparam int OP_LO   = 13;
    localparam int IMM_BIT = 12;
    localparam int RX_HI   = 11;
    localparam int RX_LO   = 9;
    localparam int RY_HI   = 2;
    localparam int RY_LO   = 0;
    localparam int IMM9_HI = 8;
    localparam int IMM9_LO = 0;

    function automatic logic [15:0] mk_instr(
        input logic [2:0] op,
        input logic       imm,
        input logic [2:0] rx,
        input logic [8:0] imm9
    );
        logic [15:0] w;
        w                  = '0;
        w[OP_HI:OP_LO]     = op;
        w[IMM_BIT]         = imm;
        w[RX_HI:RX_LO]     = rx;
        w[IMM9_HI:IMM9_LO] = imm9;
        return w;
    endfunction

    function automatic logic [15:0] mk_reg(
        input logic [2:0] op,
        input logic [2:0] rx,
        input logic [2:0] ry
    );
        logic [15:0] w;
        w              = '0;
        w[OP_HI:OP_LO] = op;
        w[RX_HI:RX_LO] = rx;
        w[RY_HI:RY_LO] = ry;
        return w;
    endfunction

endpackage

// File: rtl/instr_sequencer_prog_ram.sv
// Program RAM: one write port, one registered read port, no reset.
// Write-first on an address collision so a write and start can share a cycle.
module prog_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [15:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [15:0]       rdata_o
);

    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_o <= wdata_i;
        end else begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Feeds a stored program to the processor one run/DIN issue at a time,
// waiting for done between instructions, with a done watchdog.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_50MHz,
    input  logic              reset_n,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [15:0]       prog_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              done,
    output logic              run,
    output logic [15:0]       DIN,
    output logic              busy,
    output logic              finished,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] pc
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [7:0]        wdog_q, wdog_d;
    logic              run_q, run_d;
    logic [15:0]       din_q, din_d;
    logic              busy_q, busy_d;
    logic              fin_q, fin_d;
    logic              terr_q, terr_d;
    logic [15:0]       rdata;
    logic [ADDR_W:0]   len_clamp;
    logic              idle_like;

    assign len_clamp = (prog_len > (ADDR_W+1)'(DEPTH))
                     ? (ADDR_W+1)'(DEPTH) : prog_len;
    assign idle_like = (state_q == S_IDLE) || (state_q == S_END);

    // Read address tracks pc_d so mem[pc] is already registered in FETCH
    prog_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk_50MHz),
        .we_i    (prog_we && idle_like),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_d),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        wdog_d  = wdog_q;
        run_d   = 1'b0;
        din_d   = din_q;
        fin_d   = fin_q;
        terr_d  = terr_q;
        unique case (state_q)
            S_IDLE, S_END: begin
                state_d = S_IDLE;
                if (start) begin
                    terr_d = 1'b0;
                    pc_d   = '0;
                    len_d  = len_clamp;
                    if (len_clamp == '0) begin
                        state_d = S_END;
                        fin_d   = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        fin_d   = 1'b0;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_ISSUE;
                run_d   = 1'b1;
                din_d   = rdata;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                wdog_d  = '0;
            end
            S_WAIT: begin
                wdog_d = wdog_q + 8'd1;
                if (done) begin
                    if ({1'b0, pc_q} == len_q - (ADDR_W+1)'(1)) begin
                        state_d = S_END;
                        fin_d   = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = pc_q + ADDR_W'(1);
                    end
                end else if (wdog_d == 8'(TIMEOUT - 1)) begin
                    state_d = S_END;
                    terr_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_FETCH) || (state_d == S_ISSUE)
              || (state_d == S_WAIT);
    end

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            wdog_q  <= '0;
            run_q   <= 1'b0;
            din_q   <= 16'h0000;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            wdog_q  <= wdog_d;
            run_q   <= run_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            terr_q  <= terr_d;
        end
    end

    assign run         = run_q;
    assign DIN         = din_q;
    assign busy        = busy_q;
    assign finished    = fin_q;
    assign timeout_err = terr_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed and randomized bench for instr_sequencer with a program-level
// reference model and a scripted done responder.
module tb_instr_sequencer;
    import instr_seq_pkg::*;

    localparam int TO = 64;
    localparam int DP = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        done = 1'b0;
    logic        run;
    logic [15:0] DIN;
    logic        busy;
    logic        finished;
    logic        timeout_err;
    logic [3:0]  pc;

    instr_sequencer #(.DEPTH(DP), .ADDR_W(4), .TIMEOUT(TO)) dut (
        .clk_50MHz   (clk),
        .reset_n     (reset_n),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_len    (prog_len),
        .start       (start),
        .done        (done),
        .run         (run),
        .DIN         (DIN),
        .busy        (busy),
        .finished    (finished),
        .timeout_err (timeout_err),
        .pc          (pc)
    );

    always #10 clk = ~clk;

    int          cyc = 0;
    int          mode = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] mem_m [DP];
    int          run_cyc [$];
    logic [15:0] run_din [$];
    int          acc_delay [$];
    int          done_at [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: logs every run and schedules done pulses for it
    always @(negedge clk) begin
        int d;
        if (run) begin
            run_cyc.push_back(cyc);
            run_din.push_back(DIN);
            case (mode)
                0: d = 3;
                1: begin
                    done_at.push_back(cyc);
                    d = 1;
                end
                2: d = -1;
                default: begin
                    if ($urandom_range(0, 1) == 1) done_at.push_back(cyc);
                    d = int'($urandom_range(1, 12));
                end
            endcase
            if (d > 0) done_at.push_back(cyc + d);
            acc_delay.push_back(d);
        end
        done = 1'b0;
        for (int i = done_at.size() - 1; i >= 0; i--) begin
            if (done_at[i] == cyc) begin
                done = 1'b1;
                done_at.delete(i);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input logic [15:0] d);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = 4'(a);
        prog_data = d;
        mem_m[a]  = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic run_prog(input int len, input int md, input bit inject,
                            output int s_cyc, output int fin_cyc,
                            output int err_cyc);
        run_cyc.delete();
        run_din.delete();
        acc_delay.delete();
        mode = md;
        @(negedge clk);
        prog_len = 5'(len);
        start    = 1'b1;
        s_cyc    = cyc;
        @(negedge clk);
        start   = 1'b0;
        fin_cyc = -1;
        err_cyc = -1;
        for (int k = 0; k < 2000; k++) begin
            if (inject && k == 3) begin
                start     = 1'b1;
                prog_we   = 1'b1;
                prog_addr = 4'd1;
                prog_data = ~mem_m[1];
            end else if (inject && k == 4) begin
                start   = 1'b0;
                prog_we = 1'b0;
            end
            if (finished && fin_cyc < 0) fin_cyc = cyc;
            if (timeout_err && err_cyc < 0) err_cyc = cyc;
            if (!busy) break;
            @(negedge clk);
        end
        check("completion_bound", 32'(busy), 32'd0);
    endtask

    task automatic check_seq(input string tag, input int len,
                             input int s_cyc, input int fin_cyc);
        int n;
        int last;
        n = (len > DP) ? DP : len;
        check({tag, "_runs"}, 32'(run_cyc.size()), 32'(n));
        for (int i = 0; i < n && i < run_cyc.size(); i++) begin
            check($sformatf("%s_din%0d", tag, i), 32'(run_din[i]),
                  32'(mem_m[i]));
            if (i == 0)
                check({tag, "_first_run"}, 32'(run_cyc[0]), 32'(s_cyc + 2));
            else
                check($sformatf("%s_gap%0d", tag, i), 32'(run_cyc[i]),
                      32'(run_cyc[i-1] + acc_delay[i-1] + 2));
        end
        check({tag, "_finished"}, 32'(finished), 32'd1);
        check({tag, "_terr"}, 32'(timeout_err), 32'd0);
        if (n > 0 && run_cyc.size() == n) begin
            last = run_cyc[n-1] + acc_delay[n-1] + 1;
            check({tag, "_fin_cyc"}, 32'(fin_cyc), 32'(last));
            check({tag, "_pc"}, 32'(pc), 32'(n - 1));
        end
    endtask

    initial begin
        int s, f, e, len, k;
        reset_n   = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        prog_len  = '0;
        start     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_run", 32'(run), 32'd0);
        check("rst_din", 32'(DIN), 32'h0000);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fin", 32'(finished), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        load(0, mk_instr(OP_MV, 1'b1, 3'd0, 9'd28));
        load(1, mk_reg(OP_MV, 3'd1, 3'd0));
        load(2, mk_instr(OP_MVT, 1'b1, 3'd1, 9'h0FF));
        check("isa_w0", 32'(mem_m[0]), 32'h101C);
        check("isa_w2", 32'(mem_m[2]), 32'h32FF);
        run_prog(3, 0, 1'b0, s, f, e);
        check_seq("basic", 3, s, f);

        load(0, mk_instr(OP_MV, 1'b1, 3'd0, 9'h1FF));
        load(1, mk_instr(OP_MV, 1'b1, 3'd0, 9'h0FF));
        run_prog(2, 1, 1'b0, s, f, e);
        check_seq("early_done", 2, s, f);

        run_prog(2, 2, 1'b0, s, f, e);
        check("to_runs", 32'(run_cyc.size()), 32'd1);
        if (run_cyc.size() > 0)
            check("to_cycle", 32'(e), 32'(run_cyc[0] + TO));
        check("to_busy", 32'(busy), 32'd0);
        check("to_fin", 32'(finished), 32'd0);
        check("to_terr", 32'(timeout_err), 32'd1);
        check("to_pc", 32'(pc), 32'd0);

        run_prog(0, 0, 1'b0, s, f, e);
        check("len0_terr_clr", 32'(timeout_err), 32'd0);
        check("len0_runs", 32'(run_cyc.size()), 32'd0);
        while (cyc < s + 2) @(negedge clk);
        check("len0_fin_t2", 32'(finished), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);

        for (int i = 0; i < DP; i++)
            load(i, mk_reg(OP_ADD, 3'($urandom), 3'($urandom)) ^
                    16'($urandom_range(0, 16'h01F8)));
        run_prog(20, 3, 1'b0, s, f, e);
        check_seq("clamp20", 20, s, f);

        for (int r = 0; r < 4; r++) begin
            load(int'($urandom_range(0, DP - 1)), 16'($urandom));
            len = int'($urandom_range(1, DP));
            run_prog(len, 3, 1'b0, s, f, e);
            check_seq($sformatf("rand%0d", r), len, s, f);
        end

        run_cyc.delete();
        run_din.delete();
        acc_delay.delete();
        mode = 0;
        @(negedge clk);
        prog_len = 5'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (run_cyc.size() == 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rst_wait_bound", 32'(run_cyc.size()), 32'd1);
        @(negedge clk);
        check("rst_pre_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rstw_run", 32'(run), 32'd0);
        check("rstw_din", 32'(DIN), 32'h0000);
        check("rstw_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rstw_no_run", 32'(run_cyc.size()), 32'd1);
        run_prog(3, 0, 1'b0, s, f, e);
        check_seq("after_rst", 3, s, f);

        run_prog(3, 0, 1'b1, s, f, e);
        check_seq("busy_inject", 3, s, f);
        run_prog(3, 0, 1'b0, s, f, e);
        check_seq("ram_kept", 3, s, f);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
